nv_ram_rwsp_param: RTL and testbench

Parametrised two-port (one read, one write) synchronous RAM model for FPGA builds. It replaces the fixed-geometry rwsp RAM models with a single block.
- Depth, width and byte-write granularity are configurable.
- After reset, a hardware clear sequence zeroes the whole array.
- Read-during-write forwarding is an optional build feature.
- Read timing matches the existing rwsp models: registered read address, then registered output.

---
 rtl/nv_ram_rwsp_param.sv | 125 ++++++++++++
 tb/tb_nv_ram_rwsp_param.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_rwsp_param.sv
// Parametrised 1R/1W synchronous RAM with a post-reset hardware clear sequence.
// Optional write-first forwarding on a read/write collision: define NV_RAM_RWSP_BYPASS_EN.
module nv_ram_rwsp_param #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 256,
  parameter int MW    = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          re,
  input  logic          ore,
  output logic [DW-1:0] dout,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [MW-1:0] wmask,
  input  logic [DW-1:0] di,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic          init_busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wbe;
  logic          wr_valid;
  logic          rd_valid;
  logic [DW-1:0] rd_word;
  logic          unused_pwrbus;

  // The power-down bus only exists for drop-in compatibility with the fixed RAM models.
  assign unused_pwrbus = ^pwrbus_ram_pd;

  assign wr_valid = ({1'b0, wa} < DEPTH_W);
  assign rd_valid = ({1'b0, rd_addr_q} < DEPTH_W);
  assign rd_word  = rd_valid ? mem_q[rd_addr_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    init_busy  = (state_q == ST_CLEAR);
    mem_we     = 1'b0;
    mem_waddr  = wa;
    mem_wdata  = di;
    mem_wbe    = wmask;
    clr_addr_d = clr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    if (state_q == ST_CLEAR) begin
      mem_we     = 1'b1;
      mem_waddr  = clr_addr_q;
      mem_wdata  = '0;
      mem_wbe    = '1;
      clr_addr_d = clr_addr_q + AW'(1);
    end else begin
      mem_we = we & wr_valid;
      if (re) rd_addr_d = ra;
      if (ore) begin
        dout_d = rd_word;
`ifdef NV_RAM_RWSP_BYPASS_EN
        // Write-first: bytes being written this edge are forwarded straight to dout.
        if (we && rd_valid && (wa == rd_addr_q)) begin
          for (int i = 0; i < MW; i++) begin
            if (wmask[i]) dout_d[8*i +: 8] = di[8*i +: 8];
          end
        end
`endif
      end
    end
  end

  // A write coinciding with reset is discarded; the clear sequence rewrites everything anyway.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < MW; i++) begin
        if (mem_wbe[i]) mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr_q <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
    end else begin
      clr_addr_q <= clr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Directed bench for nv_ram_rwsp_param: a 32x256 instance and a 20x64 non-power-of-two instance.
module tb_nv_ram_rwsp_param;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pwr;

  logic [4:0]   ra, wa;
  logic         re, ore, we;
  logic [31:0]  wmask;
  logic [255:0] di, dout;
  logic         busy;

  logic [4:0]   ra_s, wa_s;
  logic         re_s, ore_s, we_s;
  logic [7:0]   wmask_s;
  logic [63:0]  di_s, dout_s;
  logic         busy_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nv_ram_rwsp_param #(.DEPTH(32), .AW(5), .DW(256)) dut (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr), .init_busy(busy)
  );

  nv_ram_rwsp_param #(.DEPTH(20), .AW(5), .DW(64)) dut_s (
    .clk(clk), .rst(rst), .ra(ra_s), .re(re_s), .ore(ore_s), .dout(dout_s),
    .wa(wa_s), .we(we_s), .wmask(wmask_s), .di(di_s), .pwrbus_ram_pd(pwr), .init_busy(busy_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [4:0] a, input logic [255:0] d, input logic [31:0] m);
    we = 1'b1; wa = a; di = d; wmask = m;
    step();
    we = 1'b0;
  endtask

  task automatic read_w(input logic [4:0] a);
    re = 1'b1; ra = a;
    step();
    re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
  endtask

  task automatic write_s(input logic [4:0] a, input logic [63:0] d);
    we_s = 1'b1; wa_s = a; di_s = d; wmask_s = 8'hFF;
    step();
    we_s = 1'b0;
  endtask

  task automatic read_s(input logic [4:0] a);
    re_s = 1'b1; ra_s = a;
    step();
    re_s = 1'b0; ore_s = 1'b1;
    step();
    ore_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (dout !== 256'h0 || busy !== 1'b1) begin
      $display("FAIL reset_state: dout=%h busy=%b, want 0 and 1", dout, busy); errors++;
    end
    // Requests during the clear must be ignored.
    rst = 1'b0;
    we = 1'b1; wa = 5'd0; di = '1; wmask = '1; re = 1'b1; ra = 5'd0; ore = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++;
      if (busy !== (i < 32) || dout !== 256'h0) begin
        $display("FAIL clear_edge%0d: busy=%b dout=%h, want busy=%b dout=0", i, busy, dout, (i < 32));
        errors++;
      end
      checks++;
      if (busy_s !== (i < 20)) begin
        $display("FAIL clear_small_edge%0d: busy=%b want %b", i, busy_s, (i < 20)); errors++;
      end
    end
    we = 1'b0; re = 1'b0; ore = 1'b0;
    for (int a = 0; a < 32; a++) begin
      read_w(5'(a));
      checks++;
      if (dout !== 256'h0) begin
        $display("FAIL cleared_word%0d: got %h want 0", a, dout); errors++;
      end
    end
  endtask

  task automatic test_basic_read();
    logic [255:0] exp_v;
    exp_v = {32{8'hA5}};
    write_w(5'd7, exp_v, '1);
    read_w(5'd7);
    checks++;
    if (dout !== exp_v) begin
      $display("FAIL basic_read: got %h want %h", dout, exp_v); errors++;
    end
    // re without ore changes the address but not dout.
    for (int i = 0; i < 5; i++) begin
      re = 1'b1; ra = 5'd3;
      step();
      checks++;
      if (dout !== exp_v) begin
        $display("FAIL hold%0d: got %h want %h", i, dout, exp_v); errors++;
      end
    end
    re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
    checks++;
    if (dout !== 256'h0) begin
      $display("FAIL readdress: got %h want 0", dout); errors++;
    end
  endtask

  task automatic test_byte_mask();
    logic [255:0] exp_v;
    write_w(5'd3, '1, 32'h0000_0005);
    read_w(5'd3);
    exp_v = 256'h00FF00FF;
    checks++;
    if (dout !== exp_v) begin
      $display("FAIL mask_0005: got %h want %h", dout, exp_v); errors++;
    end
    write_w(5'd3, {32{8'h11}}, 32'h8000_0000);
    read_w(5'd3);
    exp_v = 256'h00FF00FF | (256'h11 << 248);
    checks++;
    if (dout !== exp_v) begin
      $display("FAIL mask_top: got %h want %h", dout, exp_v); errors++;
    end
    write_w(5'd3, {32{8'h77}}, 32'h0);
    read_w(5'd3);
    checks++;
    if (dout !== exp_v) begin
      $display("FAIL mask_zero: got %h want %h", dout, exp_v); errors++;
    end
  endtask

  task automatic test_collision();
    logic [255:0] exp_v, mix;
    mix = {{31{8'h22}}, 8'h33};
    write_w(5'd9, {32{8'h11}}, '1);
    re = 1'b1; ra = 5'd9;
    step();
    re = 1'b0;
    we = 1'b1; wa = 5'd9; di = {32{8'h22}}; wmask = '1; ore = 1'b1;
    step();
    we = 1'b0;
`ifdef NV_RAM_RWSP_BYPASS_EN
    exp_v = {32{8'h22}};
`else
    exp_v = {32{8'h11}};
`endif
    checks++;
    if (dout !== exp_v) begin
      $display("FAIL collide_full: got %h want %h", dout, exp_v); errors++;
    end
    step();
    checks++;
    if (dout !== {32{8'h22}}) begin
      $display("FAIL collide_after: got %h want %h", dout, {32{8'h22}}); errors++;
    end
    we = 1'b1; wa = 5'd9; di = {32{8'h33}}; wmask = 32'h1;
    step();
    we = 1'b0;
`ifdef NV_RAM_RWSP_BYPASS_EN
    exp_v = mix;
`else
    exp_v = {32{8'h22}};
`endif
    checks++;
    if (dout !== exp_v) begin
      $display("FAIL collide_partial: got %h want %h", dout, exp_v); errors++;
    end
    step();
    checks++;
    if (dout !== mix) begin
      $display("FAIL collide_partial_after: got %h want %h", dout, mix); errors++;
    end
    we = 1'b1; wa = 5'd10; di = {32{8'h44}}; wmask = '1;
    step();
    we = 1'b0; ore = 1'b0;
    checks++;
    if (dout !== mix) begin
      $display("FAIL other_addr_write: got %h want %h", dout, mix); errors++;
    end
  endtask

  task automatic test_back_to_back();
    re = 1'b1; ra = 5'd7;
    step();
    ra = 5'd9; ore = 1'b1;
    step();
    checks++;
    if (dout !== {32{8'hA5}}) begin
      $display("FAIL b2b_first: got %h want %h", dout, {32{8'hA5}}); errors++;
    end
    re = 1'b0;
    step();
    ore = 1'b0;
    checks++;
    if (dout !== {{31{8'h22}}, 8'h33}) begin
      $display("FAIL b2b_second: got %h want %h", dout, {{31{8'h22}}, 8'h33}); errors++;
    end
  endtask

  task automatic test_mid_reset();
    logic [255:0] dead;
    dead = {16{16'hDEAD}};
    write_w(5'd4, dead, '1);
    read_w(5'd4);
    checks++;
    if (dout !== dead) begin
      $display("FAIL pre_reset_read: got %h want %h", dout, dead); errors++;
    end
    rst = 1'b1; we = 1'b1; wa = 5'd5; di = '1; wmask = '1;
    step();
    rst = 1'b0; we = 1'b0;
    checks++;
    if (dout !== 256'h0 || busy !== 1'b1) begin
      $display("FAIL mid_reset_state: dout=%h busy=%b, want 0 and 1", dout, busy); errors++;
    end
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++;
      if (busy !== (i < 32)) begin
        $display("FAIL reclear_edge%0d: busy=%b want %b", i, busy, (i < 32)); errors++;
      end
    end
    checks++;
    if (dout !== 256'h0) begin
      $display("FAIL reclear_dout: got %h want 0", dout); errors++;
    end
    read_w(5'd4);
    checks++;
    if (dout !== 256'h0) begin
      $display("FAIL reclear_m4: got %h want 0", dout); errors++;
    end
    read_w(5'd5);
    checks++;
    if (dout !== 256'h0) begin
      $display("FAIL reclear_m5: got %h want 0", dout); errors++;
    end
  endtask

  task automatic test_small_geometry();
    write_s(5'd25, 64'h0123_4567_89AB_CDEF);
    write_s(5'd19, 64'hCAFE_F00D_1234_5678);
    read_s(5'd25);
    checks++;
    if (dout_s !== 64'h0) begin
      $display("FAIL small_oob_read: got %h want 0", dout_s); errors++;
    end
    read_s(5'd5);
    checks++;
    if (dout_s !== 64'h0) begin
      $display("FAIL small_alias5: got %h want 0", dout_s); errors++;
    end
    read_s(5'd9);
    checks++;
    if (dout_s !== 64'h0) begin
      $display("FAIL small_alias9: got %h want 0", dout_s); errors++;
    end
    read_s(5'd19);
    checks++;
    if (dout_s !== 64'hCAFE_F00D_1234_5678) begin
      $display("FAIL small_last_word: got %h want %h", dout_s, 64'hCAFE_F00D_1234_5678); errors++;
    end
  endtask

  initial begin
    pwr = 32'h0;
    rst = 1'b1;
    ra = '0; wa = '0; re = 1'b0; ore = 1'b0; we = 1'b0; wmask = '0; di = '0;
    ra_s = '0; wa_s = '0; re_s = 1'b0; ore_s = 1'b0; we_s = 1'b0; wmask_s = '0; di_s = '0;
    test_reset();
    test_basic_read();
    test_byte_mask();
    test_collision();
    test_back_to_back();
    test_mid_reset();
    test_small_geometry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
